// File: rtl/adc_pll_ctrl_pkg.sv
// adc_pll_ctrl_pkg: sequencer state type, phase sizing and counter-width helpers
// shared by the ADC sampling-PLL controller slice.
package adc_pll_ctrl_pkg;

  localparam int PHASE_W    = 2;
  localparam int NUM_PHASES = 4;

  typedef enum logic [2:0] {
    RST,
    WAIT_LOCK,
    SETTLE,
    MEASURE,
    SELECT,
    RUN,
    FAIL
  } state_e;

  // width able to hold 0..n-1, never narrower than one bit
  function automatic int cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adc_pll_ctrl_if.sv
// adc_pll_ctrl_if: PLL wrapper and ADC capture-mux signals of the sequencer.
// ADC_PLL_CTRL_MANUAL_PHASE_EN adds manual_en / manual_phase.
interface adc_pll_ctrl_if
  import adc_pll_ctrl_pkg::*;
#(
  parameter int SW = 9
);

  logic               start;
  logic               pll_locked;
  logic               pll_rst;
  logic               pat_ok;
  logic [PHASE_W-1:0] phase_sel;
  logic               ready;
  logic               fail;
  logic [SW-1:0]      best_score;
  logic [7:0]         lock_loss_cnt;
`ifdef ADC_PLL_CTRL_MANUAL_PHASE_EN
  logic               manual_en;
  logic [PHASE_W-1:0] manual_phase;
`endif

`ifdef ADC_PLL_CTRL_MANUAL_PHASE_EN
  modport master (
    input  start, pll_locked, pat_ok,
    input  manual_en, manual_phase,
    output pll_rst, phase_sel, ready, fail,
    output best_score, lock_loss_cnt
  );
  modport slave (
    output start, pll_locked, pat_ok,
    output manual_en, manual_phase,
    input  pll_rst, phase_sel, ready, fail,
    input  best_score, lock_loss_cnt
  );
`else
  modport master (
    input  start, pll_locked, pat_ok,
    output pll_rst, phase_sel, ready, fail,
    output best_score, lock_loss_cnt
  );
  modport slave (
    output start, pll_locked, pat_ok,
    input  pll_rst, phase_sel, ready, fail,
    input  best_score, lock_loss_cnt
  );
`endif

endinterface

// File: rtl/adc_sync2.sv
// adc_sync2: two-flop synchroniser for the asynchronous PLL lock flag,
// cleared to 0 by the asynchronous active-low reset.
module adc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_pll_ctrl.sv
// adc_pll_ctrl: PLL reset/lock sequencer with 4-phase ADC capture training.
// Option ADC_PLL_CTRL_MANUAL_PHASE_EN: manual phase bypass of the scan.
module adc_pll_ctrl
  import adc_pll_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYC     = 100,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 100000,
  parameter int MAX_RETRIES      = 3,
  parameter int SETTLE_CYC       = 64,
  parameter int WINDOW_CYC       = 256,
  parameter int MIN_SCORE        = 200
) (
  input  logic           refclk,
  input  logic           rst_n,
  adc_pll_ctrl_if.master bus
);

  localparam int SW   = $clog2(WINDOW_CYC + 1);
  localparam int CMAX = max2(max2(RST_HOLD_CYC, LOCK_TIMEOUT_CYC),
                             max2(SETTLE_CYC, WINDOW_CYC));
  localparam int CW   = cw(CMAX);
  localparam int STW  = cw(LOCK_STABLE_CYC);
  localparam int RW   = cw(MAX_RETRIES + 1);

  localparam logic [CW-1:0]  LD_HOLD = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0]  LD_TOUT = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]  LD_SETL = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0]  LD_WIN  = CW'(WINDOW_CYC - 1);
  localparam logic [STW-1:0] STB_END = STW'(LOCK_STABLE_CYC - 1);
  localparam logic [RW-1:0]  RTY_END = RW'(MAX_RETRIES - 1);
  localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(NUM_PHASES - 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [STW-1:0]     stab_q, stab_d;
  logic [SW-1:0]      score_q, score_d;
  logic [SW-1:0]      best_q, best_d;
  logic [PHASE_W-1:0] best_ph_q, best_ph_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] sel_q, sel_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [7:0]         loss_q, loss_d;

  logic               synced;
  logic               cnt_z;
  logic               qual;
  logic [SW-1:0]      win;
  logic               lost;
  logic               clr;

  adc_sync2 u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.pll_locked),
    .q     (synced)
  );

  assign cnt_z = (cnt_q == '0);
  assign qual  = synced && (stab_q == STB_END);
  assign win   = score_q + SW'(bus.pat_ok);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST;
      cnt_q     <= LD_HOLD;
      stab_q    <= '0;
      score_q   <= '0;
      best_q    <= '0;
      best_ph_q <= '0;
      phase_q   <= '0;
      sel_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      score_q   <= score_d;
      best_q    <= best_d;
      best_ph_q <= best_ph_d;
      phase_q   <= phase_d;
      sel_q     <= sel_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stab_d    = '0;
    score_d   = score_q;
    best_d    = best_q;
    best_ph_d = best_ph_q;
    phase_d   = phase_q;
    sel_d     = sel_q;
    retry_d   = retry_q;
    lost      = 1'b0;
    clr       = 1'b0;

    unique case (state_q)
      RST: begin
        if (cnt_z) begin
          state_d = WAIT_LOCK;
          cnt_d   = LD_TOUT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      WAIT_LOCK: begin
        stab_d = synced ? stab_q + STW'(1) : '0;
        if (qual) begin
          clr     = 1'b1;
          state_d = SETTLE;
          cnt_d   = LD_SETL;
          sel_d   = '0;
`ifdef ADC_PLL_CTRL_MANUAL_PHASE_EN
          if (bus.manual_en) begin
            state_d = RUN;
            sel_d   = bus.manual_phase;
          end
`endif
        end else if (cnt_z) begin
          retry_d = retry_q + RW'(1);
          cnt_d   = LD_HOLD;
          state_d = (retry_q == RTY_END) ? FAIL : RST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      SETTLE: begin
        if (!synced) begin
          lost = 1'b1;
        end else if (cnt_z) begin
          state_d = MEASURE;
          cnt_d   = LD_WIN;
          score_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      MEASURE: begin
        if (!synced) begin
          lost = 1'b1;
        end else begin
          score_d = win;
          if (!cnt_z) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            // strict compare keeps the lower phase on a tie
            if (win > best_q) begin
              best_d    = win;
              best_ph_d = phase_q;
            end
            if (phase_q == PH_LAST) begin
              state_d = SELECT;
            end else begin
              phase_d = phase_q + PHASE_W'(1);
              sel_d   = phase_q + PHASE_W'(1);
              state_d = SETTLE;
              cnt_d   = LD_SETL;
            end
          end
        end
      end

      SELECT: begin
        if (32'(best_q) >= MIN_SCORE) begin
          sel_d   = best_ph_q;
          state_d = RUN;
        end else begin
          state_d = FAIL;
        end
      end

      RUN: begin
        if (!synced || bus.start) begin
          state_d = RST;
          cnt_d   = LD_HOLD;
          retry_d = '0;
          lost    = !synced;
          clr     = bus.start;
        end
      end

      FAIL: begin
        if (bus.start) begin
          state_d = RST;
          cnt_d   = LD_HOLD;
          retry_d = '0;
          clr     = 1'b1;
        end
      end

      default: begin
        state_d = RST;
        cnt_d   = LD_HOLD;
      end
    endcase

    // lock lost during training aborts the scan
    if (lost && (state_q != RUN)) begin
      state_d = RST;
      cnt_d   = LD_HOLD;
      clr     = 1'b1;
    end

    if (clr) begin
      score_d   = '0;
      best_d    = '0;
      best_ph_d = '0;
      phase_d   = '0;
    end

    loss_d = (lost && (loss_q != 8'hff)) ? loss_q + 8'd1 : loss_q;
  end

  assign bus.pll_rst       = (state_q == RST) || (state_q == FAIL);
  assign bus.ready         = (state_q == RUN);
  assign bus.fail          = (state_q == FAIL);
  assign bus.phase_sel     = sel_q;
  assign bus.best_score    = best_q;
  assign bus.lock_loss_cnt = loss_q;

endmodule
